// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR block: maximal-length tap masks
// and the default seed helper.
package lfsr_pkg;

  localparam logic [4:1]  TAPS_4  = 4'hC;
  localparam logic [8:1]  TAPS_8  = 8'hB8;
  localparam logic [16:1] TAPS_16 = 16'hD008;
  localparam logic [24:1] TAPS_24 = 24'hE10000;
  localparam logic [32:1] TAPS_32 = 32'h80200003;

  // Seed with only bit 1 set; callers size-cast to their width.
  function automatic logic [63:0] default_seed();
    return 64'd1;
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Feedback parity for a Fibonacci LFSR: XOR of the tapped
// state bits.
module lfsr_feedback #(
  parameter int N = 24,
  parameter logic [N:1] TAPS = {N{1'b0}}
) (
  input  logic [N:1] state_i,
  output logic       fb_o
);

  assign fb_o = ^(state_i & TAPS);

endmodule

// File: rtl/lfsr_core.sv
// Free-running N-bit Fibonacci LFSR with m-sequence output.
// Define LFSR_CORE_LOCKUP_RECOVER_EN to reload SEED from all-zero.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int N = 24,
  parameter logic [N:1] TAPS = TAPS_24,
  parameter logic [N:1] SEED = N'(default_seed())
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [N:1] q_out,
  output logic       m_seq
);

  if (N < 2) begin : g_bad_n
    $error("lfsr_core: N must be at least 2");
  end
  if (!TAPS[N]) begin : g_bad_taps
    $error("lfsr_core: TAPS[N] must be set");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_core: SEED must be nonzero");
  end

  logic [N:1] state_q;
  logic [N:1] state_d;
  logic       fb;

  lfsr_feedback #(
    .N    (N),
    .TAPS (TAPS)
  ) u_fb (
    .state_i (state_q),
    .fb_o    (fb)
  );

  always_comb begin
    state_d = {state_q[N-1:1], fb};
`ifdef LFSR_CORE_LOCKUP_RECOVER_EN
    // All-zero never leaves on its own; reload to restart the sequence.
    if (state_q == '0) begin
      state_d = SEED;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign q_out = state_q;
  assign m_seq = state_q[N];

endmodule

// File: tb/tb_lfsr_core.sv
// Bench for lfsr_core: default 24-bit instance and a 4-bit instance,
// each checked every cycle against an arithmetic reference.
module tb_lfsr_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst4_n = 1'b0;
  logic [24:1] q24;
  logic        ms24;
  logic [4:1]  q4;
  logic        ms4;

  int total = 0;
  int bad = 0;
  logic chk24 = 1'b1;
  logic chk4 = 1'b1;
  logic [63:0] m24 = 64'd1;
  logic [63:0] m4 = 64'd1;

  always #5 clk = ~clk;

  lfsr_core dut24 (
    .clk   (clk),
    .rst_n (rst_n),
    .q_out (q24),
    .m_seq (ms24)
  );

  lfsr_core #(
    .N    (4),
    .TAPS (4'hC),
    .SEED (4'h1)
  ) dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .q_out (q4),
    .m_seq (ms4)
  );

  // Next state: shift left by one, parity of tapped bits enters bit 1.
  function automatic logic [63:0] step(
    input logic [63:0] s, input logic [63:0] taps, input int n);
    int ones;
    logic [63:0] mask;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      if (s[i] && taps[i]) ones++;
    end
    mask = (64'd1 << n) - 64'd1;
    return ((s << 1) | 64'(ones % 2)) & mask;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m24 <= 64'd1;
    else m24 <= step(m24, 64'hE10000, 24);
  end

  always @(posedge clk or negedge rst4_n) begin
    if (!rst4_n) m4 <= 64'd1;
    else m4 <= step(m4, 64'hC, 4);
  end

  always @(negedge clk) begin
    if (chk24) begin
      check("q24_model", 64'(q24), m24);
      check("mseq24_model", 64'(ms24), 64'(m24[23]));
    end
    if (chk4) begin
      check("q4_model", 64'(q4), m4);
      check("mseq4_model", 64'(ms4), 64'(m4[3]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  logic [4:1] seen [1:15];

  initial begin
    int hold;
    int ones;
    int distinct;
    logic dup;

    #20;
    check("reset_q24", 64'(q24), 64'h000001);
    check("reset_mseq24", 64'(ms24), 64'd0);
    rst_n = 1'b1;

    for (int k = 1; k <= 23; k++) begin
      @(posedge clk);
      #1;
      case (k)
        1:  check("clk1", 64'(q24), 64'h000002);
        16: check("clk16", 64'(q24), 64'h010000);
        17: check("clk17", 64'(q24), 64'h020001);
        20: check("clk20", 64'(q24), 64'h100008);
        22: begin
          check("clk22", 64'(q24), 64'h400021);
          check("clk22_mseq", 64'(ms24), 64'd0);
        end
        23: begin
          check("clk23", 64'(q24), 64'h800043);
          check("clk23_mseq", 64'(ms24), 64'd1);
        end
        default: ;
      endcase
    end

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_q24", 64'(q24), 64'h000001);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 40; r++) begin
      hold = $urandom_range(1, 200);
      repeat (hold) @(posedge clk);
      #($urandom_range(1, 4));
      rst_n = 1'b0;
      #1;
      check("rand_async_reset", 64'(q24), 64'h000001);
      hold = $urandom_range(1, 3);
      repeat (hold) @(negedge clk);
      rst_n = 1'b1;
    end

    @(negedge clk);
    rst4_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      seen[k] = q4;
    end
    ones = 0;
    distinct = 0;
    for (int k = 1; k <= 15; k++) begin
      if (seen[k][4]) ones++;
      dup = (seen[k] == 4'h0);
      for (int j = 1; j < k; j++) begin
        if (seen[j] == seen[k]) dup = 1'b1;
      end
      if (!dup) distinct++;
    end
    check("n4_distinct_nonzero", 64'(distinct), 64'd15);
    check("n4_period_end", 64'(seen[15]), 64'h1);
    check("n4_mseq_ones", 64'(ones), 64'd8);

    @(negedge clk);
    chk4 = 1'b0;
    force dut4.state_q = 4'h0;
    #1;
    release dut4.state_q;
    #1;
    check("lockup_forced", 64'(q4), 64'h0);
`ifdef LFSR_CORE_LOCKUP_RECOVER_EN
    @(posedge clk);
    #1;
    check("lockup_recover", 64'(q4), 64'h1);
    @(posedge clk);
    #1;
    check("lockup_resume", 64'(q4), 64'h2);
`else
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("lockup_sticky", 64'(q4), 64'h0);
      check("lockup_sticky_mseq", 64'(ms4), 64'h0);
    end
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
